booth_mult_seq: RTL and testbench

Sequential radix-2 Booth multiplier producing the signed 2N-bit product consumed by the datapath's result register. Accepts two signed N-bit operands on a one-cycle `start`, iterates one Booth step per rising clock edge, then presents the product on `result` with a one-cycle `done` pulse. Sits upstream of the falling-edge result register. `result` changes only on rising edges, so it is stable at the following falling-edge capture.

---
 rtl/booth_mult_pkg.sv | 28 ++
 rtl/booth_mult_seq_step.sv | 34 +++
 rtl/booth_mult_seq.sv | 98 +++++++++
 tb/tb_booth_mult_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states,
// Booth operation encoding and the recoding helper.
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB
    } booth_op_t;

    // Radix-2 Booth recoding of the {Q[0], Q-1} bit pair.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
        booth_op_t op;
        case ({q0, q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One combinational Booth iteration: conditional add/subtract of M into ACC,
// then arithmetic right shift of {ACC, Q, Q-1} by one bit.
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N:0]   m,
    output logic [N:0]   acc_next,
    output logic [N-1:0] q_next,
    output logic         q_m1_next
);

    booth_op_t  op;
    logic [N:0] sum;

    always_comb begin
        op = booth_decode(q[0], q_m1);
        case (op)
            OP_ADD:  sum = acc + m;
            OP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
    end

    // The sign bit of the N+1-bit sum is replicated into the vacated MSB.
    assign acc_next  = {sum[N], sum[N:1]};
    assign q_next    = {sum[0], q[N-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per rising edge, signed
// 2N-bit product written on entry to DONE and held until the next completion.
module booth_mult_seq
    import booth_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] result,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    state_t         state_reg, state_next;
    logic [N:0]     acc_reg, m_reg;
    logic [N-1:0]   q_reg;
    logic           q_m1_reg;
    logic [CW-1:0]  count_reg;

    logic [N:0]     acc_step;
    logic [N-1:0]   q_step;
    logic           q_m1_step;
    logic           last_step;

    booth_step #(.N(N)) u_step (
        .acc       (acc_reg),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .m         (m_reg),
        .acc_next  (acc_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    assign last_step = (count_reg == CW'(1));

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            m_reg     <= '0;
            q_reg     <= '0;
            q_m1_reg  <= 1'b0;
            count_reg <= '0;
            result    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // N+1-bit multiplicand lets -2^(N-1) be negated exactly.
                        m_reg     <= {a[N-1], a};
                        acc_reg   <= '0;
                        q_reg     <= b;
                        q_m1_reg  <= 1'b0;
                        count_reg <= CW'(N);
                    end
                end
                CALC: begin
                    acc_reg   <= acc_step;
                    q_reg     <= q_step;
                    q_m1_reg  <= q_m1_step;
                    count_reg <= count_reg - CW'(1);
                    if (last_step) result <= {acc_step[N-1:0], q_step};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at N=4 and N=8 using per-width
// expected-product scoreboards.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  result4;
    logic        busy4, done4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] result8;
    logic        busy8, done8;

    logic [7:0]  sb4[$];
    logic [15:0] sb8[$];
    int          n_vec = 0;
    int          n_err = 0;

    booth_mult_seq #(.N(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .result (result4),
        .busy   (busy4),
        .done   (done4)
    );

    booth_mult_seq #(.N(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .result (result8),
        .busy   (busy8),
        .done   (done8)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[7:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = $signed(x) * $signed(y);
        return p[15:0];
    endfunction

    // One N=4 operation: start at a falling edge, wait for done, check product,
    // latency, busy length and that done is a single-cycle pulse.
    task automatic run_op4(input logic [3:0] x, input logic [3:0] y);
        int lat = 0;
        int busy_cnt = 0;
        logic [7:0] exp_val;
        @(negedge clk);
        start4 = 1'b1; a4 = x; b4 = y;
        sb4.push_back(ref4(x, y));
        while (lat < 20) begin
            @(negedge clk);
            start4 = 1'b0;
            lat++;
            if (busy4) busy_cnt++;
            if (done4) break;
        end
        n_vec++;
        if (done4 !== 1'b1) begin
            n_err++;
            $display("FAIL n4_timeout a=%0d b=%0d: done=%b after %0d cycles, required done=1", $signed(x), $signed(y), done4, lat);
            void'(sb4.pop_back());
            return;
        end
        exp_val = sb4.pop_front();
        $display("n4 op %0d * %0d -> result=%h (expect %h) latency=%0d busy_cycles=%0d", $signed(x), $signed(y), result4, exp_val, lat, busy_cnt);
        n_vec++;
        if (result4 !== exp_val) begin
            n_err++;
            $display("FAIL n4_result: got %h, required %h", result4, exp_val);
        end
        n_vec++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL n4_latency: got %0d, required 5", lat);
        end
        n_vec++;
        if (busy_cnt != 5) begin
            n_err++;
            $display("FAIL n4_busy_len: got %0d, required 5", busy_cnt);
        end
        @(negedge clk);
        n_vec++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL n4_after_done: done=%b busy=%b, required 0 0", done4, busy4);
        end
        n_vec++;
        if (result4 !== exp_val) begin
            n_err++;
            $display("FAIL n4_result_hold: got %h, required %h", result4, exp_val);
        end
    endtask

    task automatic run_op8(input logic [7:0] x, input logic [7:0] y);
        int lat = 0;
        logic [15:0] exp_val;
        @(negedge clk);
        start8 = 1'b1; a8 = x; b8 = y;
        sb8.push_back(ref8(x, y));
        while (lat < 30) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            lat++;
            if (done8) break;
        end
        n_vec++;
        if (done8 !== 1'b1) begin
            n_err++;
            $display("FAIL n8_timeout a=%0d b=%0d: done=%b after %0d cycles, required done=1", $signed(x), $signed(y), done8, lat);
            void'(sb8.pop_back());
            return;
        end
        exp_val = sb8.pop_front();
        $display("n8 op %0d * %0d -> result=%h (expect %h) latency=%0d", $signed(x), $signed(y), result8, exp_val, lat);
        n_vec++;
        if (result8 !== exp_val) begin
            n_err++;
            $display("FAIL n8_result: got %h, required %h", result8, exp_val);
        end
        n_vec++;
        if (lat != 9) begin
            n_err++;
            $display("FAIL n8_latency: got %0d, required 9", lat);
        end
        @(negedge clk);
        n_vec++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL n8_after_done: done=%b busy=%b, required 0 0", done8, busy8);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        $display("reset state: result4=%h busy4=%b done4=%b result8=%h busy8=%b done8=%b", result4, busy4, done4, result8, busy8, done8);
        n_vec++;
        if (result4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_n4: result=%h busy=%b done=%b, required 00 0 0", result4, busy4, done4);
        end
        n_vec++;
        if (result8 !== 16'h0000 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_n8: result=%h busy=%b done=%b, required 0000 0 0", result8, busy8, done8);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op4(4'd3, 4'd5);
    endtask

    task automatic test_signed();
        run_op4(4'hD, 4'd7);
        run_op4(4'd7, 4'hD);
        run_op4(4'h8, 4'h8);
        run_op4(4'h8, 4'd7);
        run_op4(4'd0, 4'h8);
    endtask

    // start stays high through CALC and DONE; only the first IDLE edge may accept it.
    task automatic test_back_to_back();
        int cyc = 0;
        int dones = 0;
        int first_cyc = 0;
        int second_cyc = 0;
        logic [7:0] exp_val;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
        sb4.push_back(ref4(4'd3, 4'd5));
        sb4.push_back(ref4(4'd2, 4'd2));
        while (cyc < 40 && dones < 2) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin a4 = 4'd2; b4 = 4'd2; end
            if (cyc == 6) begin
                n_vec++;
                if (busy4 !== 1'b0 || done4 !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy4, done4);
                end
            end
            if (done4) begin
                dones++;
                exp_val = (sb4.size() > 0) ? sb4.pop_front() : 8'hXX;
                $display("b2b done #%0d at cycle %0d result=%h (expect %h)", dones, cyc, result4, exp_val);
                n_vec++;
                if (result4 !== exp_val) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: got %h, required %h", dones, result4, exp_val);
                end
                if (dones == 1) first_cyc = cyc; else second_cyc = cyc;
            end
        end
        start4 = 1'b0;
        n_vec++;
        if (first_cyc != 5 || second_cyc != 11) begin
            n_err++;
            $display("FAIL b2b_timing: done at cycles %0d,%0d, required 5,11", first_cyc, second_cyc);
        end
        while (sb4.size() > 0) void'(sb4.pop_front());
        @(negedge clk);
        n_vec++;
        if (done4 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_single_pulse: done=%b, required 0", done4);
        end
    endtask

    task automatic test_async_reset();
        int seen = 0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-CALC: result4=%h busy4=%b done4=%b", result4, busy4, done4);
        n_vec++;
        if (result4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: result=%h busy=%b done=%b, required 00 0 0", result4, busy4, done4);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL async_rst_no_done: %0d cycles busy/done after abort, required 0", seen);
        end
        run_op4(4'd2, 4'd3);
    endtask

    task automatic test_sweep_n8();
        logic [7:0] xs[5] = '{8'h80, 8'h80, 8'h7F, 8'h7F, 8'h00};
        logic [7:0] ys[5] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'h5A};
        for (int i = 0; i < 5; i++) run_op8(xs[i], ys[i]);
        for (int i = 0; i < 20; i++) run_op8(8'($urandom), 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_async_reset();
        test_sweep_n8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
